// File: rtl/rr_arbiter_stage.sv
// Round-robin N:1 arbiter feeding a single registered valid/ready output beat.
// One-cycle latency, one beat per clock, pointer advances only on a real transfer.
module rr_arbiter_stage #(
   parameter int unsigned N         = 4,
   parameter int unsigned bus_width = 4,
   parameter int unsigned ID_W      = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N-1:0]           valide_in,
   input  logic [N*bus_width-1:0] Datain,
   output logic [N-1:0]           ready_out,
   output logic                   valide_out,
   output logic [bus_width-1:0]   Dataout,
   output logic [ID_W-1:0]        grant_id,
   input  logic                   ready_in
);

   logic                 valid_q, valid_d;
   logic [bus_width-1:0] data_q, data_d;
   logic [ID_W-1:0]      gid_q, gid_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;

   logic                 load_en;
   logic                 found;
   logic [ID_W-1:0]      win_idx;
   logic [ID_W:0]        sum;
   logic [bus_width-1:0] win_data;

   assign load_en = ~valid_q | ready_in;

   // Rotating priority search starting at ptr_q; sum is one bit wider so the wrap is exact.
   always_comb begin
      found    = 1'b0;
      win_idx  = '0;
      sum      = '0;
      win_data = '0;
      for (int unsigned k = 0; k < N; k++) begin
         sum = {1'b0, ptr_q} + (ID_W+1)'(k);
         if (sum >= (ID_W+1)'(N)) begin
            sum = sum - (ID_W+1)'(N);
         end
         if (!found && valide_in[sum[ID_W-1:0]]) begin
            found   = 1'b1;
            win_idx = sum[ID_W-1:0];
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (ID_W'(i) == win_idx) begin
            win_data = Datain[i*bus_width +: bus_width];
         end
      end
   end

   always_comb begin
      ready_out = '0;
      if (found && load_en && !rst) begin
         ready_out[win_idx] = 1'b1;
      end
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      gid_d   = gid_q;
      ptr_d   = ptr_q;
      if (load_en) begin
         if (found) begin
            valid_d = 1'b1;
            data_d  = win_data;
            gid_d   = win_idx;
            ptr_d   = (win_idx == ID_W'(N-1)) ? '0 : win_idx + 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         gid_q   <= '0;
         ptr_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         gid_q   <= gid_d;
         ptr_q   <= ptr_d;
      end
   end

   assign valide_out = valid_q;
   assign Dataout    = data_q;
   assign grant_id   = gid_q;

endmodule
